// File: rtl/md_sched_pkg.sv
// Shared types and widths for the multiply/divide sequencer.
//   md_op_e    : MD operation code presented by the E stage
//   md_state_e : sequencer FSM state
//   md_res_t   : 64-bit {hi, lo} result payload
package md_sched_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage <-> MD sequencer signal bundle.
//   master : E/D-stage side (drives start/op/a/b/cancel/md_use_d)
//   slave  : sequencer side (drives busy/stall/hi/lo)
interface md_sched_if;
  import md_sched_pkg::*;

  logic            start;
  md_op_e          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            cancel;
  logic            md_use_d;
  logic            busy;
  logic            stall;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, cancel, md_use_d,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, md_use_d,
    output busy, stall, hi, lo
  );

endinterface

// File: rtl/md_sched_alu.sv
// Combinational multiply/divide datapath.
//   op_i     : operation code
//   a_i, b_i : rs / rt operands
//   res_c_o  : {hi, lo} result (combinational), zero for non-arithmetic ops
module md_sched_alu
  import md_sched_pkg::*;
(
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output md_res_t         res_c_o
);

  logic            mul_signed;
  logic            div_signed;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] ua;
  logic [XLEN-1:0] ub;
  logic [XLEN-1:0] uq;
  logic [XLEN-1:0] ur;
  logic            neg_q;
  logic            neg_r;

  // One 64-bit multiplier and one unsigned divider serve signed and unsigned ops.
  always_comb begin
    res_c_o    = '0;
    mul_signed = (op_i == MD_MULT);
    div_signed = (op_i == MD_DIV);

    // Low 64 bits of a 64x64 product are correct for both signed and unsigned.
    a_ext = mul_signed ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
    b_ext = mul_signed ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
    prod  = a_ext * b_ext;

    // Signed divide on magnitudes; 8000_0000 / -1 falls out as 8000_0000 rem 0.
    ua    = (div_signed && a_i[XLEN-1]) ? -a_i : a_i;
    ub    = (div_signed && b_i[XLEN-1]) ? -b_i : b_i;
    uq    = ua / ub;
    ur    = ua % ub;
    neg_q = div_signed & (a_i[XLEN-1] ^ b_i[XLEN-1]);
    neg_r = div_signed & a_i[XLEN-1];

    case (op_i)
      MD_MULT, MD_MULTU: begin
        res_c_o.hi = prod[2*XLEN-1:XLEN];
        res_c_o.lo = prod[XLEN-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_i == '0) begin
          res_c_o.hi = a_i;
          res_c_o.lo = '1;
        end else begin
          res_c_o.hi = neg_r ? -ur : ur;
          res_c_o.lo = neg_q ? -uq : uq;
        end
      end
      default: res_c_o = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: accepts one MD op per start pulse, holds busy for
// the op's fixed latency, owns HI/LO and raises the D-stage stall request.
//   clk : clock, rising edge
//   clr : asynchronous active-high reset
//   md  : md_sched_if.slave (start/op/a/b/cancel/md_use_d in; busy/stall/hi/lo out)
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       clr,
  md_sched_if.slave md
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pend_hi_q, pend_hi_d;
  logic [XLEN-1:0] pend_lo_q, pend_lo_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            start_eff_c;
  md_res_t         alu_res;

  md_sched_alu u_alu (
    .op_i    (md.op),
    .a_i     (md.a),
    .b_i     (md.b),
    .res_c_o (alu_res)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next state: results are captured at the start edge and published on the cnt==0 edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    start_eff_c = md.start & ~md.cancel & (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start_eff_c) begin
          case (md.op)
            MD_MULT, MD_MULTU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
              pend_hi_d = alu_res.hi;
              pend_lo_d = alu_res.lo;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              pend_hi_d = alu_res.hi;
              pend_lo_d = alu_res.lo;
            end
            MD_MTHI: hi_d = md.a;
            MD_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // cancel is ignored here: the owning instruction has already left E.
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md.busy  = (state_q == ST_RUN);
  // Combinational so the start cycle itself holds back a following MD instruction.
  assign md.stall = md.md_use_d & ((state_q == ST_RUN) | start_eff_c);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  import md_sched_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  md_sched_if mdif ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .clr (clr),
    .md  (mdif)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    mdif.start  = 1'b0;
    mdif.op     = MD_NONE;
    mdif.a      = '0;
    mdif.b      = '0;
    mdif.cancel = 1'b0;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    mdif.start  = 1'b1;
    mdif.op     = op;
    mdif.a      = a;
    mdif.b      = b;
    mdif.cancel = cancel;
    tick();
    drive_idle();
  endtask

  // Counts post-edge samples with busy high; bounded so a stuck busy cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    while (mdif.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    drive_idle();
    mdif.md_use_d = 1'b0;
    tick();
    tick();
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mdif.busy); end
    checks++; if (mdif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mdif.stall); end
    checks++; if (mdif.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", mdif.hi); end
    checks++; if (mdif.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", mdif.lo); end
    clr = 1'b0;
    tick();
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", mdif.busy); end
  endtask

  task automatic test_mult;
    int n;
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    checks++; if (mdif.hi !== 32'h0) begin errors++; $display("FAIL mult_hi_early got %h want 0", mdif.hi); end
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_latency got %0d want 5", n); end
    checks++; if (mdif.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", mdif.hi); end
    checks++; if (mdif.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", mdif.lo); end
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_latency got %0d want 5", n); end
    checks++; if ({mdif.hi, mdif.lo} !== 64'h1_FFFF_FFFE) begin
      errors++; $display("FAIL multu_res got %h_%h want 00000001_fffffffe", mdif.hi, mdif.lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_latency got %0d want 10", n); end
    checks++; if (mdif.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", mdif.lo); end
    checks++; if (mdif.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", mdif.hi); end
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    checks++; if (mdif.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", mdif.lo); end
    checks++; if (mdif.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", mdif.hi); end
  endtask

  task automatic test_div_special;
    int n;
    issue(MD_DIV, 32'd5, 32'd0, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div0_latency got %0d want 10", n); end
    checks++; if (mdif.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", mdif.lo); end
    checks++; if (mdif.hi !== 32'd5) begin errors++; $display("FAIL div0_hi got %h want 00000005", mdif.hi); end
    issue(MD_DIVU, 32'd9, 32'd0, 1'b0);
    count_busy(n);
    checks++; if ({mdif.hi, mdif.lo} !== 64'h0000_0009_FFFF_FFFF) begin
      errors++; $display("FAIL divu0_res got %h_%h want 00000009_ffffffff", mdif.hi, mdif.lo);
    end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    checks++; if (mdif.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", mdif.lo); end
    checks++; if (mdif.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", mdif.hi); end
  endtask

  task automatic test_cancel;
    int n;
    mdif.md_use_d = 1'b1;
    mdif.start    = 1'b1;
    mdif.op       = MD_MULT;
    mdif.a        = 32'd2;
    mdif.b        = 32'd2;
    mdif.cancel   = 1'b1;
    #1;
    checks++; if (mdif.stall !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b want 0", mdif.stall); end
    tick();
    drive_idle();
    mdif.md_use_d = 1'b0;
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", mdif.busy); end
    tick();
    checks++; if ({mdif.hi, mdif.lo} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL cancel_hilo got %h_%h want 00000000_80000000", mdif.hi, mdif.lo);
    end
    // Cancel raised in the middle of RUN must not abort the op.
    issue(MD_MULT, 32'd6, 32'd7, 1'b0);
    n = 0;
    while (mdif.busy === 1'b1 && n < 40) begin
      mdif.cancel = (n == 2);
      n++;
      tick();
    end
    mdif.cancel = 1'b0;
    checks++; if (n != 5) begin errors++; $display("FAIL cancel_mid_latency got %0d want 5", n); end
    checks++; if ({mdif.hi, mdif.lo} !== 64'h0000_0000_0000_002A) begin
      errors++; $display("FAIL cancel_mid_res got %h_%h want 00000000_0000002a", mdif.hi, mdif.lo);
    end
  endtask

  task automatic test_stall;
    mdif.md_use_d = 1'b1;
    mdif.start    = 1'b1;
    mdif.op       = MD_DIVU;
    mdif.a        = 32'd50;
    mdif.b        = 32'd8;
    #1;
    checks++; if (mdif.stall !== 1'b1) begin errors++; $display("FAIL stall_start_cycle got %b want 1", mdif.stall); end
    tick();
    drive_idle();
    for (int k = 0; k < 10; k++) begin
      checks++; if ({mdif.busy, mdif.stall} !== 2'b11) begin
        errors++; $display("FAIL stall_run%0d busy/stall got %b want 11", k, {mdif.busy, mdif.stall});
      end
      // A second start while busy must be ignored.
      mdif.start = (k == 3);
      mdif.op    = (k == 3) ? MD_MULT : MD_NONE;
      mdif.a     = 32'd3;
      mdif.b     = 32'd3;
      tick();
    end
    drive_idle();
    checks++; if ({mdif.busy, mdif.stall} !== 2'b00) begin
      errors++; $display("FAIL stall_drop busy/stall got %b want 00", {mdif.busy, mdif.stall});
    end
    checks++; if ({mdif.hi, mdif.lo} !== 64'h0000_0002_0000_0006) begin
      errors++; $display("FAIL stall_res got %h_%h want 00000002_00000006", mdif.hi, mdif.lo);
    end
    tick();
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b want 0", mdif.busy); end
    mdif.md_use_d = 1'b0;
  endtask

  task automatic test_move;
    issue(MD_MTHI, 32'd1234, 32'd0, 1'b0);
    checks++; if (mdif.hi !== 32'd1234) begin errors++; $display("FAIL mthi_hi got %h want 000004d2", mdif.hi); end
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", mdif.busy); end
    checks++; if (mdif.lo !== 32'd6) begin errors++; $display("FAIL mthi_lo got %h want 00000006", mdif.lo); end
    issue(MD_MTLO, 32'h0000_CAFE, 32'd0, 1'b0);
    checks++; if ({mdif.hi, mdif.lo} !== 64'h0000_04D2_0000_CAFE) begin
      errors++; $display("FAIL mtlo_res got %h_%h want 000004d2_0000cafe", mdif.hi, mdif.lo);
    end
    issue(MD_RSVD, 32'd77, 32'd1, 1'b0);
    issue(MD_NONE, 32'd88, 32'd1, 1'b0);
    checks++; if ({mdif.busy, mdif.hi, mdif.lo} !== {1'b0, 64'h0000_04D2_0000_CAFE}) begin
      errors++; $display("FAIL noop_state got %b %h_%h want 0 000004d2_0000cafe", mdif.busy, mdif.hi, mdif.lo);
    end
  endtask

  task automatic test_clr_mid;
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    tick();
    checks++; if (mdif.busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got %b want 1", mdif.busy); end
    #2 clr = 1'b1;
    #1;
    checks++; if ({mdif.busy, mdif.hi, mdif.lo} !== 65'h0) begin
      errors++; $display("FAIL clr_async got %b %h_%h want 0 0_0", mdif.busy, mdif.hi, mdif.lo);
    end
    tick();
    clr = 1'b0;
    tick();
    tick();
    checks++; if ({mdif.busy, mdif.hi, mdif.lo} !== 65'h0) begin
      errors++; $display("FAIL clr_after got %b %h_%h want 0 0_0", mdif.busy, mdif.hi, mdif.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_cancel();
    test_stall();
    test_move();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
